// File: rtl/minmax_reduce_nbit_pkg.sv
// Shared encodings and default sizing for the streaming min/max reduction engine.
package minmax_reduce_nbit_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_LEN_MAX = 256;

  localparam logic MODE_MIN = 1'b0;
  localparam logic MODE_MAX = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/minmax_reduce_nbit_cmp_gt_nbit.sv
// WIDTH-bit greater-than comparator; signed mode flips both MSBs so one unsigned compare serves both.
module cmp_gt_nbit #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SIGNED,
  output logic             Y
);

  logic [WIDTH-1:0] a_adj;
  logic [WIDTH-1:0] b_adj;

  assign a_adj = {A[WIDTH-1] ^ SIGNED, A[WIDTH-2:0]};
  assign b_adj = {B[WIDTH-1] ^ SIGNED, B[WIDTH-2:0]};
  assign Y     = (a_adj > b_adj);

endmodule

// File: rtl/minmax_reduce_nbit.sv
// Frame-level min/max reduction over a valid/ready stream; reports the extreme value and its first index.
module minmax_reduce_nbit #(
  parameter int  WIDTH   = minmax_reduce_nbit_pkg::DEF_WIDTH,
  parameter int  LEN_MAX = minmax_reduce_nbit_pkg::DEF_LEN_MAX,
  localparam int IDXW    = $clog2(LEN_MAX)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MODE_MAX,
  input  logic             SIGNED,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_ovf
);
  import minmax_reduce_nbit_pkg::*;

  localparam logic [IDXW-1:0] CNT_TOP = IDXW'(LEN_MAX - 1);

  state_e           state_q;
  logic             in_ready_q, out_valid_q;
  logic             mode_max_q, signed_q;
  logic [WIDTH-1:0] best_q, best_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [IDXW-1:0]  cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic [WIDTH-1:0] cmp_a, cmp_b;
  logic             better;

  assign accept = in_valid && in_ready_q;

  // Operand swap turns the single greater-than into "candidate strictly better than best".
  assign cmp_a = (mode_max_q == minmax_reduce_nbit_pkg::MODE_MAX) ? in_data : best_q;
  assign cmp_b = (mode_max_q == minmax_reduce_nbit_pkg::MODE_MAX) ? best_q  : in_data;

  cmp_gt_nbit #(.WIDTH(WIDTH)) u_cmp (
    .A      (cmp_a),
    .B      (cmp_b),
    .SIGNED (signed_q),
    .Y      (better)
  );

  // sat_q marks that index LEN_MAX-1 is used up; only a beat beyond that flags overflow.
  always_comb begin
    best_d = best_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    sat_d  = sat_q;
    ovf_d  = ovf_q;
    if (state_q == S_IDLE) begin
      best_d = in_data;
      idx_d  = '0;
      cnt_d  = IDXW'(1);
      sat_d  = 1'b0;
      ovf_d  = 1'b0;
    end else begin
      if (better) begin
        best_d = in_data;
        idx_d  = cnt_q;
      end
      if (sat_q) begin
        ovf_d = 1'b1;
      end else if (cnt_q == CNT_TOP) begin
        sat_d = 1'b1;
      end else begin
        cnt_d = cnt_q + IDXW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      mode_max_q  <= 1'b0;
      signed_q    <= 1'b0;
      best_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      if (accept) begin
        best_q <= best_d;
        idx_q  <= idx_d;
        cnt_q  <= cnt_d;
        sat_q  <= sat_d;
        ovf_q  <= ovf_d;
      end
      case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            mode_max_q <= MODE_MAX;
            signed_q   <= SIGNED;
            state_q    <= S_ACC;
            if (in_last) begin
              state_q     <= S_HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        S_ACC: begin
          if (accept && in_last) begin
            state_q     <= S_HOLD;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = best_q;
  assign out_idx   = idx_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_minmax_reduce_nbit.sv
// Directed bench: a 16-bit/LEN_MAX=256 instance and an 8-bit/LEN_MAX=4 instance share the stimulus bus.
module tb_minmax_reduce_nbit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode_max = 1'b0;
  logic        sgn = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_data = '0;
  logic        va = 1'b0;
  logic        vb = 1'b0;

  logic        a_in_ready, a_out_valid, a_out_ovf;
  logic [15:0] a_out_data;
  logic [7:0]  a_out_idx;
  logic        b_in_ready, b_out_valid, b_out_ovf;
  logic [7:0]  b_out_data;
  logic [1:0]  b_out_idx;

  always #5 clk = ~clk;

  minmax_reduce_nbit #(.WIDTH(16), .LEN_MAX(256)) dut_a (
    .clk(clk), .rst(rst), .MODE_MAX(mode_max), .SIGNED(sgn),
    .in_valid(va), .in_ready(a_in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_idx(a_out_idx), .out_ovf(a_out_ovf)
  );

  minmax_reduce_nbit #(.WIDTH(8), .LEN_MAX(4)) dut_b (
    .clk(clk), .rst(rst), .MODE_MAX(mode_max), .SIGNED(sgn),
    .in_valid(vb), .in_ready(b_in_ready), .in_data(in_data[7:0]), .in_last(in_last),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_idx(b_out_idx), .out_ovf(b_out_ovf)
  );

  bit          sel;
  logic        r_ready, r_valid, r_ovf;
  logic [15:0] r_data;
  logic [7:0]  r_idx;

  always_comb begin
    r_ready = sel ? b_in_ready  : a_in_ready;
    r_valid = sel ? b_out_valid : a_out_valid;
    r_ovf   = sel ? b_out_ovf   : a_out_ovf;
    r_data  = sel ? {8'h00, b_out_data} : a_out_data;
    r_idx   = sel ? {6'b0, b_out_idx}   : a_out_idx;
  end

  typedef logic [15:0] beats_t [6];
  typedef struct {
    string       name;
    bit          sel;
    bit          mmax;
    bit          sgn;
    int          n;
    beats_t      d;
    logic [15:0] exp_data;
    int          exp_idx;
    bit          exp_ovf;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input bit s, input bit mm, input bit sg, input int n,
                     input beats_t d, input logic [15:0] ed, input int ei, input bit eo);
    vec_t v;
    v.name = nm; v.sel = s; v.mmax = mm; v.sgn = sg; v.n = n; v.d = d;
    v.exp_data = ed; v.exp_idx = ei; v.exp_ovf = eo;
    vecs.push_back(v);
  endtask

  task automatic beat(input logic [15:0] d, input bit last, input bit mm, input bit sg);
    in_data = d; in_last = last; mode_max = mm; sgn = sg;
    if (sel) vb = 1'b1; else va = 1'b1;
    @(posedge clk); #1;
    va = 1'b0; vb = 1'b0; in_last = 1'b0;
  endtask

  task automatic release_result(input string nm);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({nm, ".valid_drop"}, r_valid, 0);
    check({nm, ".ready_back"}, r_ready, 1);
  endtask

  task automatic run_frame(input vec_t v);
    sel = v.sel;
    for (int i = 0; i < v.n; i++) begin
      check($sformatf("%s.ready%0d", v.name, i), r_ready, 1);
      beat(v.d[i], (i == v.n - 1), v.mmax, v.sgn);
    end
    check({v.name, ".valid"}, r_valid, 1);
    check({v.name, ".data"}, r_data, v.exp_data);
    check({v.name, ".idx"}, r_idx, v.exp_idx);
    check({v.name, ".ovf"}, r_ovf, v.exp_ovf);
    release_result(v.name);
  endtask

  initial begin
    add("umin16",   0, 0, 0, 4, '{16'h0005, 16'hFFFF, 16'h0003, 16'h0003, 16'h0, 16'h0}, 16'h0003, 2, 0);
    add("smax8",    1, 1, 1, 3, '{16'h80, 16'h7F, 16'hFF, 16'h0, 16'h0, 16'h0}, 16'h007F, 1, 0);
    add("smin8",    1, 0, 1, 3, '{16'h80, 16'h7F, 16'hFF, 16'h0, 16'h0, 16'h0}, 16'h0080, 0, 0);
    add("umin8",    1, 0, 0, 3, '{16'h80, 16'h7F, 16'hFF, 16'h0, 16'h0, 16'h0}, 16'h007F, 1, 0);
    add("umax8",    1, 1, 0, 3, '{16'h80, 16'h7F, 16'hFF, 16'h0, 16'h0, 16'h0}, 16'h00FF, 2, 0);
    add("ovf4",     1, 0, 0, 6, '{16'h5, 16'h5, 16'h5, 16'h5, 16'h5, 16'h1}, 16'h0001, 3, 1);
    add("smax16",   0, 1, 1, 3, '{16'h8000, 16'hFFFE, 16'hFFFF, 16'h0, 16'h0, 16'h0}, 16'hFFFF, 2, 0);
    add("tie_umax", 1, 1, 0, 4, '{16'h3, 16'h9, 16'h9, 16'h2, 16'h0, 16'h0}, 16'h0009, 1, 0);
    add("smin_neg", 1, 0, 1, 3, '{16'h02, 16'hFE, 16'h01, 16'h0, 16'h0, 16'h0}, 16'h00FE, 1, 0);

    // Reset state of both instances
    rst = 1'b1;
    @(posedge clk); #1;
    sel = 0;
    check("rst.a_ready", r_ready, 0);
    check("rst.a_valid", r_valid, 0);
    check("rst.a_data", r_data, 0);
    check("rst.a_idx", r_idx, 0);
    check("rst.a_ovf", r_ovf, 0);
    sel = 1;
    check("rst.b_ready", r_ready, 0);
    check("rst.b_valid", r_valid, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst.b_ready_after", r_ready, 1);
    sel = 0;
    check("rst.a_ready_after", r_ready, 1);

    foreach (vecs[k]) run_frame(vecs[k]);

    // Single-beat frame held under back-pressure with a competing beat offered
    sel = 0;
    check("hold.ready0", r_ready, 1);
    beat(16'h1234, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("hold.valid%0d", k), r_valid, 1);
      check($sformatf("hold.ready%0d", k), r_ready, 0);
      check($sformatf("hold.data%0d", k), r_data, 16'h1234);
      check($sformatf("hold.idx%0d", k), r_idx, 0);
      in_data = 16'h0001; in_last = 1'b1; va = 1'b1;
      @(posedge clk); #1;
    end
    va = 1'b0; in_last = 1'b0;
    check("hold.data_final", r_data, 16'h1234);
    release_result("hold");

    // Mode change mid-frame is ignored
    sel = 1;
    beat(16'd9, 1'b0, 1'b0, 1'b0);
    beat(16'd2, 1'b0, 1'b1, 1'b0);
    beat(16'd7, 1'b1, 1'b1, 1'b0);
    check("toggle.valid", r_valid, 1);
    check("toggle.data", r_data, 2);
    check("toggle.idx", r_idx, 1);
    release_result("toggle");

    // Reset while accumulating discards the partial frame
    beat(16'h01, 1'b0, 1'b1, 1'b1);
    beat(16'h00, 1'b0, 1'b1, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstacc.ready", r_ready, 0);
    check("rstacc.valid", r_valid, 0);
    check("rstacc.data", r_data, 0);
    @(posedge clk); #1;
    check("rstacc.ready_after", r_ready, 1);
    beat(16'd4, 1'b1, 1'b0, 1'b0);
    check("rstacc.valid2", r_valid, 1);
    check("rstacc.data2", r_data, 4);
    check("rstacc.idx2", r_idx, 0);
    check("rstacc.ovf2", r_ovf, 0);
    release_result("rstacc");

    // Reset while a result is held drops it
    beat(16'd6, 1'b1, 1'b0, 1'b0);
    check("rsthold.valid", r_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rsthold.valid_drop", r_valid, 0);
    check("rsthold.data", r_data, 0);
    @(posedge clk); #1;
    check("rsthold.ready_after", r_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/minmax_reduce_nbit.md
# minmax_reduce_nbit

Streaming min/max reduction engine: accepts a frame of WIDTH-bit operands over a valid/ready stream and returns the extreme value and its position once the frame ends. It generalises the two-operand combinational unsigned min to arbitrary width, selectable min/max and signed/unsigned modes, and sequential frame-level reduction with back-pressure. It is a benchmark-class datapath block feeding the bit-serial PIM synthesis flow and the system-level reduction tests.

## Interface
- WIDTH, 16, operand width in bits (≥2)
- LEN_MAX, 256, maximum frame length tracked by the index counter (power of two)
- IDXW, $clog2(LEN_MAX), index width (derived, not overridden)

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- MODE_MAX  in  1  0 = minimum, 1 = maximum; sampled on first beat of a frame
- SIGNED  in  1  0 = unsigned, 1 = two's-complement compare; sampled on first beat
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  WIDTH  operand
- in_last  in  1  marks final beat of frame
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  extreme value of frame
- out_idx  out  IDXW  zero-based position of first occurrence of out_data
- out_ovf  out  1  frame had more than LEN_MAX beats

## Operation
- Beat accepted when in_valid && in_ready.
- States: IDLE (no partial frame), ACC (partial frame held), HOLD (result presented).
- IDLE: in_ready=1. On accepted beat: latch MODE_MAX/SIGNED into mode regs, best←in_data, best_idx←0, cnt←1, ovf←0; go to HOLD if in_last else ACC.
- ACC: in_ready=1. On accepted beat, candidate replaces best iff strictly better (min: cand<best; max: cand>best) under latched signedness; ties keep earlier index. best_idx←cnt on replace. cnt increments. If in_last, go to HOLD.
- Mode inputs are ignored except on the first beat; mid-frame changes have no effect.
- HOLD: in_ready=0, out_valid=1, outputs stable. On out_ready go to IDLE (next beat accepted the following cycle).
- Index overflow: when cnt would reach LEN_MAX, cnt saturates at LEN_MAX-1, ovf←1; later beats still compete but a replacement records index LEN_MAX-1. out_ovf reflects ovf.
- Signed compare: invert MSB of both operands and compare unsigned.
- rst in any state: state←IDLE, out_valid=0, out_data=0, out_idx=0, out_ovf=0, cnt=0, mode regs=0; a partial frame is discarded, a held result is dropped.

## Timing
- Reset values: in_ready=0 during the rst cycle, 1 the cycle after; out_valid=0, out_data=0, out_idx=0, out_ovf=0.
- Throughput: one beat per cycle in IDLE/ACC.
- Latency: out_valid asserts the cycle after the in_last beat is accepted; single-beat frame likewise.
- Minimum frame-to-frame turnaround: result cycle + 1 (HOLD is exclusive with input).
- out_* registered; no combinational path from in_* to out_* or from out_ready to in_ready.
- Compare path: one WIDTH-bit comparator plus mux in a single cycle.

## Structure
- Shared package/header: mode encodings (MODE_MIN=0, MODE_MAX=1), state encodings (S_IDLE, S_ACC, S_HOLD), default WIDTH/LEN_MAX.
- One sub-module: cmp_gt_nbit (WIDTH param; inputs A, B, SIGNED; output Y = A>B), instantiated twice or once with operand swap for min/max selection.
- Remaining logic (FSM, best/idx/cnt registers) in the top module.

## Test plan
- Unsigned min, WIDTH=16: frame {0x0005,0xFFFF,0x0003,0x0003(last)} -> out_data=0x0003, out_idx=2, out_ovf=0, out_valid one cycle after last.
- Signed max, WIDTH=8: frame {0x80,0x7F,0xFF(last)} -> out_data=0x7F, out_idx=1; same frame signed min -> 0x80, idx 0; unsigned min -> 0x7F, idx 1.
- Single-beat frame 0x1234 with in_last, out_ready held low 5 cycles -> out_valid stays high, in_ready=0 throughout, outputs stable; release -> in_ready=1 next cycle.
- Mid-frame MODE_MAX toggle from 0 to 1 after beat 1, frame {9,2,7(last)} -> min result 2, idx 1.
- LEN_MAX=4, frame of 6 beats {5,5,5,5,5,1(last)} -> out_data=1, out_idx=3, out_ovf=1.
- rst asserted while in ACC after 2 beats, then frame {4(last)} -> result 4, idx 0; no residue from discarded beats; rst during HOLD -> out_valid=0 next cycle.
